// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared constants, FSM encoding and clog2 for the AXI read-address generator
package axi_rd_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      ADDR = 1'b1
   } rd_state_e;

   // ceil(log2(value)); 0 for value <= 1
   function automatic int clog2(input int unsigned value);
      int unsigned v;
      int          r;
      v = (value > 1) ? value - 1 : 0;
      r = 0;
      while (v != 0) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rd_credit_cnt.sv
// rtl/rd_credit_cnt.sv - saturating up/down burst credit counter with underflow flag
module rd_credit_cnt
   import axi_rd_pkg::*;
#(
   parameter int unsigned MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic [3:0] cnt_next,
   output logic       underflow
);

   localparam logic [3:0] CNT_MAX = 4'(MAX);

   logic dec_ok;

   // A decrement at zero is not a real completion: it only raises underflow
   assign dec_ok = dec && (cnt != 4'd0);

   // Value the counter takes at the next edge; simultaneous inc/dec cancel
   always_comb begin
      underflow = dec && (cnt == 4'd0);
      cnt_next  = cnt;
      if (inc && !dec_ok) begin
         if (cnt != CNT_MAX) begin
            cnt_next = cnt + 4'd1;
         end
      end else if (!inc && dec_ok) begin
         cnt_next = cnt - 4'd1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/axi_rd_addr_gen.sv
// rtl/axi_rd_addr_gen.sv - AXI4 AR-channel burst generator over a ring region; RD_ADDR_STATS_EN adds a completed-burst counter
module axi_rd_addr_gen
   import axi_rd_pkg::*;
#(
   parameter int unsigned C_ADDR_WIDTH    = 30,
   parameter int unsigned C_DATA_WIDTH    = 64,
   parameter int unsigned C_BURST_LEN     = 16,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int unsigned REGION_BYTES    = 1048576,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                    M_AXI_ACLK,
   input  logic                    M_AXI_ARESETN,
   input  logic                    rd_en,
   input  logic                    M_AXI_ARREADY,
   input  logic                    M_AXI_RVALID,
   input  logic                    M_AXI_RREADY,
   input  logic                    M_AXI_RLAST,
   output logic [C_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                    M_AXI_ARVALID,
   output logic [7:0]              M_AXI_ARLEN,
   output logic [2:0]              M_AXI_ARSIZE,
   output logic [1:0]              M_AXI_ARBURST,
   output logic [3:0]              outstanding,
   output logic                    busy,
   output logic                    burst_done,
   output logic                    rd_err,
   output logic [31:0]             burst_cnt
);

   localparam int unsigned     BURST_BYTES = C_BURST_LEN * C_DATA_WIDTH / 8;
   localparam int              OFS_W       = (clog2(REGION_BYTES) < 1) ? 1 : clog2(REGION_BYTES);
   localparam logic [OFS_W-1:0] OFS_STEP   = OFS_W'(BURST_BYTES);
   localparam logic [OFS_W-1:0] OFS_LAST   = OFS_W'(REGION_BYTES - BURST_BYTES);
   localparam logic [3:0]      MAX_OUT     = 4'(MAX_OUTSTANDING);

   if ((C_DATA_WIDTH < 8) || (C_DATA_WIDTH > 1024) || ((C_DATA_WIDTH & (C_DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
      $error("C_DATA_WIDTH must be a power of two in 8..1024");
   end
   if ((C_BURST_LEN == 0) || (C_BURST_LEN > 256)) begin : g_bad_burst_len
      $error("C_BURST_LEN must be in 1..256");
   end
   if ((4096 % BURST_BYTES) != 0) begin : g_bad_burst_bytes
      $error("burst size must divide 4096 so no burst crosses a 4 KB boundary");
   end
   if ((REGION_BYTES == 0) || ((REGION_BYTES % BURST_BYTES) != 0)) begin : g_bad_region
      $error("REGION_BYTES must be a non-zero multiple of the burst size");
   end
   if ((BASE_ADDR % BURST_BYTES) != 0) begin : g_bad_base
      $error("BASE_ADDR must be aligned to the burst size");
   end
   if ((MAX_OUTSTANDING == 0) || (MAX_OUTSTANDING > 15)) begin : g_bad_max_out
      $error("MAX_OUTSTANDING must be in 1..15");
   end

   rd_state_e        state_q;
   logic             arvalid_q;
   logic [OFS_W-1:0] offset_q;
   logic             ar_hs;
   logic             r_done;
   logic [3:0]       out_cnt;
   logic [3:0]       out_next;
   logic             underflow;
   logic             burst_done_q;
   logic             rd_err_q;

   assign ar_hs  = arvalid_q && M_AXI_ARREADY;
   assign r_done = M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST;

   rd_credit_cnt #(
      .MAX (MAX_OUTSTANDING)
   ) u_credit (
      .clk       (M_AXI_ACLK),
      .rst_n     (M_AXI_ARESETN),
      .inc       (ar_hs),
      .dec       (r_done),
      .cnt       (out_cnt),
      .cnt_next  (out_next),
      .underflow (underflow)
   );

   // AR issue FSM: decides against the post-update credit so a freed slot is reused at once
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q   <= IDLE;
         arvalid_q <= 1'b0;
         offset_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_en && (out_next < MAX_OUT)) begin
                  state_q   <= ADDR;
                  arvalid_q <= 1'b1;
               end
            end
            ADDR: begin
               if (M_AXI_ARREADY) begin
                  offset_q <= (offset_q == OFS_LAST) ? '0 : offset_q + OFS_STEP;
                  if (rd_en && (out_next < MAX_OUT)) begin
                     state_q   <= ADDR;
                     arvalid_q <= 1'b1;
                  end else begin
                     state_q   <= IDLE;
                     arvalid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               arvalid_q <= 1'b0;
            end
         endcase
      end
   end

   // Completion pulse and sticky error for RLAST arriving with nothing outstanding
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         burst_done_q <= 1'b0;
         rd_err_q     <= 1'b0;
      end else begin
         burst_done_q <= r_done && !underflow;
         rd_err_q     <= rd_err_q | underflow;
      end
   end

`ifdef RD_ADDR_STATS_EN
   logic [31:0] burst_cnt_q;

   // Free-running count of completed bursts, wraps naturally
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         burst_cnt_q <= 32'd0;
      end else if (r_done && !underflow) begin
         burst_cnt_q <= burst_cnt_q + 32'd1;
      end
   end

   assign burst_cnt = burst_cnt_q;
`else
   assign burst_cnt = 32'd0;
`endif

   assign M_AXI_ARADDR  = C_ADDR_WIDTH'(BASE_ADDR) + C_ADDR_WIDTH'(offset_q);
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARLEN   = 8'(C_BURST_LEN - 1);
   assign M_AXI_ARSIZE  = 3'(clog2(C_DATA_WIDTH / 8));
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign outstanding   = out_cnt;
   assign busy          = arvalid_q || (out_cnt != 4'd0);
   assign burst_done    = burst_done_q;
   assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_axi_rd_addr_gen.sv
// tb/tb_axi_rd_addr_gen.sv - self-checking bench for axi_rd_addr_gen with a burst-level reference model
module tb_axi_rd_addr_gen;

   localparam int MAX = 4;
   localparam int BB  = 128;
   localparam int NB0 = 1048576 / BB;
   localparam int NB1 = 512 / BB;
`ifdef RD_ADDR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rd_en = 1'b0, arready = 1'b0, rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;

   logic [29:0] araddr0, araddr1;
   logic        arvalid0, arvalid1, busy0, busy1, bd0, bd1, err0, err1;
   logic [7:0]  arlen0, arlen1;
   logic [2:0]  arsize0, arsize1;
   logic [1:0]  arburst0, arburst1;
   logic [3:0]  out0, out1;
   logic [31:0] bcnt0, bcnt1;

   int checks = 0;
   int failures = 0;

   int m_out, m_k, m_cnt;
   bit m_pend, m_bd, m_err;
   logic [29:0] q0[$];
   logic [29:0] q1[$];

   always #5 clk = ~clk;

   axi_rd_addr_gen dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .rd_en(rd_en), .M_AXI_ARREADY(arready),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RLAST(rlast),
      .M_AXI_ARADDR(araddr0), .M_AXI_ARVALID(arvalid0), .M_AXI_ARLEN(arlen0), .M_AXI_ARSIZE(arsize0),
      .M_AXI_ARBURST(arburst0), .outstanding(out0), .busy(busy0), .burst_done(bd0), .rd_err(err0),
      .burst_cnt(bcnt0)
   );

   axi_rd_addr_gen #(.REGION_BYTES(512)) dut_w (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .rd_en(rd_en), .M_AXI_ARREADY(arready),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RLAST(rlast),
      .M_AXI_ARADDR(araddr1), .M_AXI_ARVALID(arvalid1), .M_AXI_ARLEN(arlen1), .M_AXI_ARSIZE(arsize1),
      .M_AXI_ARBURST(arburst1), .outstanding(out1), .busy(busy1), .burst_done(bd1), .rd_err(err1),
      .burst_cnt(bcnt1)
   );

   function automatic logic [29:0] exp_addr(input int nb);
      return 30'((m_k % nb) * BB);
   endfunction

   task automatic model_reset();
      m_out = 0; m_k = 0; m_cnt = 0; m_pend = 1'b0; m_bd = 1'b0; m_err = 1'b0;
      q0.delete(); q1.delete();
   endtask

   // Records handshakes, advances the burst-level model by one cycle, then clocks the DUTs
   task automatic tick();
      bit hs, comp, err;
      if (arvalid0 && arready) q0.push_back(araddr0);
      if (arvalid1 && arready) q1.push_back(araddr1);
      if (rst_n) begin
         hs   = m_pend && arready;
         comp = rvalid && rready && rlast;
         err  = comp && (m_out == 0);
         if (hs) begin m_out++; m_k++; end
         if (comp && !err) begin m_out--; m_cnt++; end
         m_bd = comp && !err;
         if (err) m_err = 1'b1;
         if (!m_pend || hs) m_pend = rd_en && (m_out < MAX);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rd_en = 1'b1; arready = 1'b1; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL reset_arvalid got %b expected 0", arvalid0); end
      checks++; if (araddr0 !== 30'h0) begin failures++; $display("FAIL reset_araddr got %h expected 0", araddr0); end
      checks++; if (out0 !== 4'd0) begin failures++; $display("FAIL reset_outstanding got %0d expected 0", out0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", busy0); end
      checks++; if (bd0 !== 1'b0) begin failures++; $display("FAIL reset_burst_done got %b expected 0", bd0); end
      checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_rd_err got %b expected 0", err0); end
      checks++; if (bcnt0 !== 32'd0) begin failures++; $display("FAIL reset_burst_cnt got %0d expected 0", bcnt0); end
      checks++; if (arlen0 !== 8'd15) begin failures++; $display("FAIL arlen got %0d expected 15", arlen0); end
      checks++; if (arsize0 !== 3'd3) begin failures++; $display("FAIL arsize got %0d expected 3", arsize0); end
      checks++; if (arburst0 !== 2'b01) begin failures++; $display("FAIL arburst got %b expected 01", arburst0); end
      rst_n = 1'b1;
      tick();
      checks++; if (arvalid0 !== 1'b1) begin failures++; $display("FAIL release_arvalid got %b expected 1", arvalid0); end
   endtask

   task automatic test_fill();
      logic [29:0] exp_fill[4];
      exp_fill = '{30'h000, 30'h080, 30'h100, 30'h180};
      repeat (8) tick();
      checks++; if (q0.size() != 4) begin failures++; $display("FAIL fill_count got %0d expected 4", q0.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= q0.size() || q0[i] !== exp_fill[i]) begin
            failures++; $display("FAIL fill_addr[%0d] got %h expected %h", i, (i < q0.size()) ? q0[i] : 30'h3fffffff, exp_fill[i]);
         end
      end
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL fill_arvalid got %b expected 0", arvalid0); end
      checks++; if (out0 !== 4'd4) begin failures++; $display("FAIL fill_outstanding got %0d expected 4", out0); end
      checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL fill_busy got %b expected 1", busy0); end
   endtask

   task automatic test_complete();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      checks++; if (out0 !== 4'd3) begin failures++; $display("FAIL complete_outstanding got %0d expected 3", out0); end
      checks++; if (bd0 !== 1'b1) begin failures++; $display("FAIL complete_burst_done got %b expected 1", bd0); end
      checks++; if (arvalid0 !== 1'b1) begin failures++; $display("FAIL complete_arvalid got %b expected 1", arvalid0); end
      checks++; if (araddr0 !== 30'h200) begin failures++; $display("FAIL complete_araddr got %h expected 200", araddr0); end
      tick();
      checks++; if (bd0 !== 1'b0) begin failures++; $display("FAIL complete_pulse_width got %b expected 0", bd0); end
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL refill_arvalid got %b expected 0", arvalid0); end
      checks++; if (out0 !== 4'd4) begin failures++; $display("FAIL refill_outstanding got %0d expected 4", out0); end
      checks++; if (q0.size() != 5 || q0[q0.size()-1] !== 30'h200) begin failures++; $display("FAIL fifth_ar count %0d expected 5 at 200", q0.size()); end
   endtask

   task automatic test_wrap();
      logic [29:0] exp_w[5];
      exp_w = '{30'h000, 30'h080, 30'h100, 30'h180, 30'h000};
      checks++; if (q1.size() != 5) begin failures++; $display("FAIL wrap_count got %0d expected 5", q1.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= q1.size() || q1[i] !== exp_w[i]) begin
            failures++; $display("FAIL wrap_addr[%0d] got %h expected %h", i, (i < q1.size()) ? q1[i] : 30'h3fffffff, exp_w[i]);
         end
      end
   endtask

   task automatic test_stall();
      arready = 1'b0; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; rd_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (arvalid0 !== 1'b1 || araddr0 !== 30'h280) begin
            failures++; $display("FAIL stall_hold[%0d] arvalid %b addr %h expected 1 addr 280", i, arvalid0, araddr0);
         end
         tick();
      end
      arready = 1'b1;
      tick();
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL stall_release_arvalid got %b expected 0", arvalid0); end
      checks++; if (out0 !== 4'd4) begin failures++; $display("FAIL stall_outstanding got %0d expected 4", out0); end
      checks++; if (q0.size() != 6 || q0[q0.size()-1] !== 30'h280) begin failures++; $display("FAIL stall_handshake count %0d expected 6 at 280", q0.size()); end
      tick();
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL stall_idle got %b expected 0", arvalid0); end
   endtask

   task automatic test_random();
      logic [31:0] exp_cnt;
      for (int c = 0; c < 600; c++) begin
         rd_en   = ($urandom_range(0, 9) < 7);
         arready = 1'($urandom_range(0, 1));
         rvalid  = 1'($urandom_range(0, 1));
         rready  = ($urandom_range(0, 3) != 0);
         rlast   = (m_out > 0) && ($urandom_range(0, 2) == 0);
         tick();
         exp_cnt = STATS ? 32'(m_cnt) : 32'd0;
         checks++; if (arvalid0 !== m_pend) begin failures++; $display("FAIL rnd_arvalid c=%0d got %b expected %b", c, arvalid0, m_pend); end
         checks++; if (arvalid1 !== m_pend) begin failures++; $display("FAIL rnd_arvalid_w c=%0d got %b expected %b", c, arvalid1, m_pend); end
         checks++; if (araddr0 !== exp_addr(NB0)) begin failures++; $display("FAIL rnd_araddr c=%0d got %h expected %h", c, araddr0, exp_addr(NB0)); end
         checks++; if (araddr1 !== exp_addr(NB1)) begin failures++; $display("FAIL rnd_araddr_w c=%0d got %h expected %h", c, araddr1, exp_addr(NB1)); end
         checks++; if (out0 !== 4'(m_out)) begin failures++; $display("FAIL rnd_outstanding c=%0d got %0d expected %0d", c, out0, m_out); end
         checks++; if (bd0 !== m_bd) begin failures++; $display("FAIL rnd_burst_done c=%0d got %b expected %b", c, bd0, m_bd); end
         checks++; if (busy0 !== (m_pend || m_out != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got %b", c, busy0); end
         checks++; if (err0 !== m_err) begin failures++; $display("FAIL rnd_rd_err c=%0d got %b expected %b", c, err0, m_err); end
         checks++; if (bcnt0 !== exp_cnt) begin failures++; $display("FAIL rnd_burst_cnt c=%0d got %0d expected %0d", c, bcnt0, exp_cnt); end
      end
   endtask

   task automatic test_underflow();
      rd_en = 1'b1; arready = 1'b1; rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      repeat (3) tick();
      checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got %b expected 1", busy0); end
      rst_n = 1'b0;
      model_reset();
      #2;
      checks++; if (arvalid0 !== 1'b0 || out0 !== 4'd0 || busy0 !== 1'b0 || araddr0 !== 30'h0) begin
         failures++; $display("FAIL async_reset arvalid %b out %0d busy %b addr %h expected all 0", arvalid0, out0, busy0, araddr0);
      end
      rst_n = 1'b1; rd_en = 1'b0; arready = 1'b0;
      tick();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      tick();
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL underflow_rd_err got %b expected 1", err0); end
      checks++; if (out0 !== 4'd0) begin failures++; $display("FAIL underflow_outstanding got %0d expected 0", out0); end
      checks++; if (bd0 !== 1'b0) begin failures++; $display("FAIL underflow_burst_done got %b expected 0", bd0); end
      repeat (3) tick();
      checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL rd_err_sticky got %b expected 1", err0); end
   endtask

   task automatic test_stats();
      rd_en = 1'b1; arready = 1'b1;
      repeat (3) tick();
      rd_en = 1'b0;
      tick();
      checks++; if (out0 !== 4'd3) begin failures++; $display("FAIL stats_outstanding got %0d expected 3", out0); end
      checks++; if (arvalid0 !== 1'b0) begin failures++; $display("FAIL stats_arvalid got %b expected 0", arvalid0); end
      for (int i = 0; i < 3; i++) begin
         rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
         tick();
         checks++; if (bd0 !== 1'b1) begin failures++; $display("FAIL stats_burst_done[%0d] got %b expected 1", i, bd0); end
      end
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      tick();
      checks++; if (out0 !== 4'd0) begin failures++; $display("FAIL stats_drained got %0d expected 0", out0); end
      checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL stats_busy got %b expected 0", busy0); end
      checks++; if (bcnt0 !== (STATS ? 32'd3 : 32'd0)) begin failures++; $display("FAIL stats_burst_cnt got %0d expected %0d", bcnt0, STATS ? 3 : 0); end
      checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL stats_rd_err_kept got %b expected 1", err0); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_complete();
      test_wrap();
      test_stall();
      test_random();
      test_underflow();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
